// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, instruction field layout, fetch FSM encoding.
package cpu_defs;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned FUNC_W = 11;
  localparam int unsigned JIDX_W = 26;
  localparam int unsigned CNT_W  = 4;

  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned RS_LSB   = 21;
  localparam int unsigned RT_LSB   = 16;
  localparam int unsigned RD_LSB   = 11;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned FUNC_LSB = 0;
  localparam int unsigned JIDX_LSB = 0;

  localparam logic [OP_W-1:0] OP_J   = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ = 6'b000010;
  localparam logic [OP_W-1:0] OP_ALU = 6'b000100;
  localparam logic [OP_W-1:0] OP_SW  = 6'b001100;
  localparam logic [OP_W-1:0] OP_LW  = 6'b001110;

  typedef enum logic [3:0] {
    FS_IDLE = 4'b0001,
    FS_REQ  = 4'b0010,
    FS_WAIT = 4'b0100,
    FS_ERR  = 4'b1000
  } fetch_state_e;

  // Deferred PC update captured while a fetch is in flight.
  typedef struct packed {
    logic            sel;
    logic [XLEN-1:0] target;
  } pc_upd_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read channel (req/ack handshake).
interface instr_fetch_unit_if;
  import cpu_defs::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with deferred-update latch and branch target alignment check.
module pc_reg
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            renew,
  input  logic            sel,
  input  logic [XLEN-1:0] target,
  input  logic            hold,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            misalign_c
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_q, pend_d;
  pc_upd_t         pend_upd_q, pend_upd_d;
  pc_upd_t         new_upd, cur_upd;

  always_comb begin
    pc_d           = pc_q;
    pend_d         = pend_q;
    pend_upd_d     = pend_upd_q;
    new_upd.sel    = sel;
    new_upd.target = {target[XLEN-1:2], 2'b00};
    cur_upd        = renew ? new_upd : pend_upd_q;
    // While a fetch holds the address, park the newest request instead of applying it.
    if (renew && hold) begin
      pend_d     = 1'b1;
      pend_upd_d = new_upd;
    end else if (!hold && (renew || pend_q)) begin
      pc_d   = cur_upd.sel ? cur_upd.target : pc_q + XLEN'(4);
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_upd_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_upd_q <= pend_upd_d;
    end
  end

  assign pc         = pc_q;
  assign npc        = pc_q + XLEN'(4);
  assign misalign_c = renew && sel && (target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction register, imem req/ack FSM and fixed-field decode.
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h1000_0000,
  parameter int unsigned     TIMEOUT   = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ir_write,
  input  logic                renew_pc,
  input  logic                next_address_select,
  input  logic [XLEN-1:0]     branch_target,
  instr_fetch_unit_if.master  imem,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     npc,
  output logic [XLEN-1:0]     instruction,
  output logic [OP_W-1:0]     op_code,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [IMM_W-1:0]    imm16,
  output logic [FUNC_W-1:0]   alu_func,
  output logic [JIDX_W-1:0]   jump_index,
  output logic                instr_valid,
  output logic                fetch_busy,
  output logic                fetch_error
);

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             defer_q, defer_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             in_flight_c, hold_c, misalign_c, launch_c;

  assign in_flight_c = (state_q == FS_REQ) || (state_q == FS_WAIT);
  assign hold_c      = (state_q == FS_ERR) || (in_flight_c && !imem.imem_ack);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .renew      (renew_pc),
    .sel        (next_address_select),
    .target     (branch_target),
    .hold       (hold_c),
    .pc         (pc),
    .npc        (npc),
    .misalign_c (misalign_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    defer_d  = defer_q;
    ir_d     = ir_q;
    valid_d  = 1'b0;
    err_d    = err_q | misalign_c;
    launch_c = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        // A same-edge PC update wins; the fetch launches one cycle later from the new PC.
        if ((ir_write && armed_q) || defer_q) begin
          if (renew_pc) begin
            defer_d = 1'b1;
          end else begin
            launch_c = 1'b1;
            defer_d  = 1'b0;
            cnt_d    = '0;
            state_d  = FS_REQ;
          end
        end
      end
      FS_REQ, FS_WAIT: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = FS_IDLE;
        end else if ((5'(cnt_q) + 5'd1) == 5'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = FS_ERR;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FS_WAIT;
        end
      end
      FS_ERR: ;
      default: state_d = FS_IDLE;
    endcase
    busy_d  = (state_d == FS_REQ) || (state_d == FS_WAIT);
    armed_d = !ir_write ? 1'b1 : (launch_c ? 1'b0 : armed_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FS_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      defer_q <= 1'b0;
      ir_q    <= NOP_INSTR;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      defer_q <= defer_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign imem.imem_req  = busy_q;
  assign imem.imem_addr = pc;
  assign fetch_busy     = busy_q;
  assign instr_valid    = valid_q;
  assign fetch_error    = err_q;
  assign instruction    = ir_q;

  assign op_code    = ir_q[OP_LSB +: OP_W];
  assign rs         = ir_q[RS_LSB +: REG_W];
  assign rt         = ir_q[RT_LSB +: REG_W];
  assign rd         = ir_q[RD_LSB +: REG_W];
  assign imm16      = ir_q[IMM_LSB +: IMM_W];
  assign alu_func   = ir_q[FUNC_LSB +: FUNC_W];
  assign jump_index = ir_q[JIDX_LSB +: JIDX_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: decode table, directed corner cases, random vs model.
module tb_instr_fetch_unit;
  import cpu_defs::*;

  localparam logic [31:0] NOP = 32'h1000_0000;
  localparam int          TO  = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_write, renew_pc, next_address_select;
  logic [31:0] branch_target;
  logic [31:0] pc, npc, instruction;
  logic [5:0]  op_code;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [10:0] alu_func;
  logic [25:0] jump_index;
  logic        instr_valid, fetch_busy, fetch_error;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ir_write            (ir_write),
    .renew_pc            (renew_pc),
    .next_address_select (next_address_select),
    .branch_target       (branch_target),
    .imem                (bus),
    .pc                  (pc),
    .npc                 (npc),
    .instruction         (instruction),
    .op_code             (op_code),
    .rs                  (rs),
    .rt                  (rt),
    .rd                  (rd),
    .imm16               (imm16),
    .alu_func            (alu_func),
    .jump_index          (jump_index),
    .instr_valid         (instr_valid),
    .fetch_busy          (fetch_busy),
    .fetch_error         (fetch_error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] rdata;
    int          waits;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [10:0] func;
    logic [25:0] jidx;
  } vec_t;

  vec_t vecs[4];

  // Reference model state: phase 0 idle, 1 fetching, 2 dead after timeout.
  int          m_phase, m_miss;
  logic [31:0] m_pc, m_ir, m_ptgt;
  logic        m_err, m_valid, m_pend, m_psel, m_armed, m_defer;

  task automatic model_reset();
    m_phase = 0; m_miss = 0; m_pc = 32'h0; m_ir = NOP; m_ptgt = 32'h0;
    m_err = 1'b0; m_valid = 1'b0; m_pend = 1'b0; m_psel = 1'b0;
    m_armed = 1'b1; m_defer = 1'b0;
  endtask

  task automatic model_edge();
    bit          locked, launch, want;
    logic [31:0] tgt;
    locked = (m_phase == 2) || (m_phase == 1 && !bus.imem_ack);
    tgt    = {branch_target[31:2], 2'b00};
    launch = 1'b0;
    if (renew_pc && next_address_select && branch_target[1:0] != 2'b00) m_err = 1'b1;
    if (renew_pc && locked) begin
      m_pend = 1'b1; m_psel = next_address_select; m_ptgt = tgt;
    end else if (renew_pc) begin
      m_pc = next_address_select ? tgt : m_pc + 32'd4;
      m_pend = 1'b0;
    end else if (m_pend && !locked) begin
      m_pc = m_psel ? m_ptgt : m_pc + 32'd4;
      m_pend = 1'b0;
    end
    m_valid = 1'b0;
    if (m_phase == 1) begin
      if (bus.imem_ack) begin
        m_ir = bus.imem_rdata; m_valid = 1'b1; m_phase = 0;
      end else begin
        m_miss++;
        if (m_miss == TO) begin m_phase = 2; m_err = 1'b1; end
      end
    end else if (m_phase == 0) begin
      want = (ir_write && m_armed) || m_defer;
      if (want && renew_pc) m_defer = 1'b1;
      else if (want) begin m_phase = 1; m_miss = 0; m_defer = 1'b0; launch = 1'b1; end
    end
    if (!ir_write) m_armed = 1'b1;
    else if (launch) m_armed = 1'b0;
  endtask

  task automatic model_compare();
    chk("rnd_pc", pc, m_pc);
    chk("rnd_npc", npc, m_pc + 32'd4);
    chk("rnd_addr", bus.imem_addr, m_pc);
    chk("rnd_req", 32'(bus.imem_req), 32'(m_phase == 1));
    chk("rnd_busy", 32'(fetch_busy), 32'(m_phase == 1));
    chk("rnd_valid", 32'(instr_valid), 32'(m_valid));
    chk("rnd_err", 32'(fetch_error), 32'(m_err));
    chk("rnd_ir", instruction, m_ir);
    chk("rnd_op", 32'(op_code), 32'(m_ir >> 26));
    chk("rnd_func", 32'(alu_func), m_ir & 32'h7FF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cnt, busy_cnt, valid_cnt, addr_bad, ticks;
    logic [31:0] r;

    vecs[0] = '{32'h1022_0003, 0, 6'h04, 5'h01, 5'h02, 5'h00, 16'h0003, 11'h003, 26'h022_0003};
    vecs[1] = '{32'hFFFF_FFFF, 3, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 11'h7FF, 26'h3FF_FFFF};
    vecs[2] = '{32'h0000_0000, 1, 6'h00, 5'h00, 5'h00, 5'h00, 16'h0000, 11'h000, 26'h000_0000};
    vecs[3] = '{32'hABCD_1234, 5, 6'h2A, 5'h1E, 5'h0D, 5'h02, 16'h1234, 11'h234, 26'h3CD_1234};

    reset = 1'b0; ir_write = 0; renew_pc = 0; next_address_select = 0;
    branch_target = 32'h0; bus.imem_ack = 0; bus.imem_rdata = 32'h0;
    tick(); tick();
    reset = 1'b1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", instruction, NOP);
    chk("rst_op", 32'(op_code), 32'h04);
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_busy", 32'(fetch_busy), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_err", 32'(fetch_error), 0);

    // Decode table: each entry fetched with its own number of wait cycles.
    for (int i = 0; i < 4; i++) begin
      ir_write = 1'b1; bus.imem_rdata = vecs[i].rdata;
      tick();
      ir_write = 1'b0;
      req_cnt = 0; busy_cnt = 0; valid_cnt = 0; addr_bad = 0;
      for (int c = 0; c <= vecs[i].waits; c++) begin
        if (bus.imem_req) req_cnt++;
        if (fetch_busy) busy_cnt++;
        if (bus.imem_addr !== 32'h0) addr_bad++;
        valid_cnt += int'(instr_valid);
        bus.imem_ack = (c == vecs[i].waits);
        tick();
      end
      bus.imem_ack = 1'b0;
      valid_cnt += int'(instr_valid);
      chk("tbl_valid_now", 32'(instr_valid), 1);
      chk("tbl_ir", instruction, vecs[i].rdata);
      chk("tbl_op", 32'(op_code), 32'(vecs[i].op));
      chk("tbl_rs", 32'(rs), 32'(vecs[i].rs));
      chk("tbl_rt", 32'(rt), 32'(vecs[i].rt));
      chk("tbl_rd", 32'(rd), 32'(vecs[i].rd));
      chk("tbl_imm", 32'(imm16), 32'(vecs[i].imm));
      chk("tbl_func", 32'(alu_func), 32'(vecs[i].func));
      chk("tbl_jidx", 32'(jump_index), 32'(vecs[i].jidx));
      chk("tbl_req_done", 32'(bus.imem_req), 0);
      tick();
      valid_cnt += int'(instr_valid);
      chk("tbl_req_cycles", 32'(req_cnt), 32'(vecs[i].waits + 1));
      chk("tbl_busy_cycles", 32'(busy_cnt), 32'(vecs[i].waits + 1));
      chk("tbl_addr_stable", 32'(addr_bad), 0);
      chk("tbl_valid_pulses", 32'(valid_cnt), 1);
    end

    // PC wrap and branch.
    renew_pc = 1'b1; next_address_select = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    chk("pc_set_top", pc, 32'hFFFF_FFFC);
    chk("npc_wrap", npc, 32'h0);
    next_address_select = 1'b0;
    tick();
    chk("pc_wrap", pc, 32'h0);
    next_address_select = 1'b1; branch_target = 32'h40;
    tick();
    renew_pc = 1'b0;
    chk("pc_branch", pc, 32'h40);
    chk("pc_branch_err", 32'(fetch_error), 0);

    // Same-edge update and fetch request: PC first, fetch next cycle; held ir_write fetches once.
    renew_pc = 1'b1; branch_target = 32'h100; ir_write = 1'b1;
    tick();
    renew_pc = 1'b0;
    chk("same_pc", pc, 32'h100);
    chk("same_req_late", 32'(bus.imem_req), 0);
    tick();
    chk("same_req", 32'(bus.imem_req), 1);
    chk("same_addr", bus.imem_addr, 32'h100);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hABCD_1234;
    tick();
    bus.imem_ack = 1'b0;
    chk("same_valid", 32'(instr_valid), 1);
    chk("same_ir", instruction, 32'hABCD_1234);
    tick();
    chk("held_no_refetch", 32'(bus.imem_req), 0);
    tick();
    chk("held_no_refetch2", 32'(bus.imem_req), 0);
    ir_write = 1'b0;
    tick();

    // PC update during WAIT is deferred to the completion edge.
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    tick();
    renew_pc = 1'b1; next_address_select = 1'b1; branch_target = 32'h80;
    tick();
    renew_pc = 1'b0;
    chk("defer_addr", bus.imem_addr, 32'h100);
    chk("defer_pc", pc, 32'h100);
    chk("defer_req", 32'(bus.imem_req), 1);
    tick();
    chk("defer_addr2", bus.imem_addr, 32'h100);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0000;
    tick();
    bus.imem_ack = 1'b0;
    chk("defer_applied", pc, 32'h80);
    chk("defer_valid", 32'(instr_valid), 1);

    // Misaligned target: masked load plus sticky error.
    renew_pc = 1'b1; branch_target = 32'h42;
    tick();
    renew_pc = 1'b0;
    chk("mis_pc", pc, 32'h40);
    chk("mis_err", 32'(fetch_error), 1);
    tick();
    chk("mis_err_sticky", 32'(fetch_error), 1);
    reset = 1'b0;
    #1;
    chk("rst2_err", 32'(fetch_error), 0);
    chk("rst2_pc", pc, 32'h0);
    tick();
    reset = 1'b1;

    // Timeout into ERR.
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    repeat (TO - 1) tick();
    chk("to_err_early", 32'(fetch_error), 0);
    chk("to_req_early", 32'(bus.imem_req), 1);
    tick();
    chk("to_err", 32'(fetch_error), 1);
    chk("to_req_drop", 32'(bus.imem_req), 0);
    chk("to_busy_drop", 32'(fetch_busy), 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    chk("err_ack_ignored", instruction, NOP);
    chk("err_no_valid", 32'(instr_valid), 0);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    chk("err_stuck", 32'(bus.imem_req), 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst3_err", 32'(fetch_error), 0);

    // Asynchronous abort mid-fetch; a late ack is ignored.
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    chk("abort_req_before", 32'(bus.imem_req), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_req_async", 32'(bus.imem_req), 0);
    chk("abort_busy_async", 32'(fetch_busy), 0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    tick();
    reset = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("abort_ir", instruction, NOP);
    chk("abort_valid", 32'(instr_valid), 0);

    // Randomized traffic against the reference model.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    ticks = 0;
    for (int n = 0; n < 2500; n++) begin
      r = $urandom();
      ir_write            = (r[1:0] == 2'b00);
      renew_pc            = (r[4:2] == 3'b000);
      next_address_select = r[5];
      bus.imem_ack        = (r[7:6] == 2'b00) || (r[7:6] == 2'b01 && r[8]);
      bus.imem_rdata      = $urandom();
      r = $urandom();
      branch_target = (r[31:28] == 4'h0) ? r : {r[31:2], 2'b00};
      ticks++;
      if (m_phase == 2 || ticks >= 200) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        ticks = 0;
      end else begin
        @(posedge clk);
        model_edge();
        #1;
      end
      model_compare();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
